// File: rtl/avl_bus_arbiter_pkg.sv
// Shared types for the Avalon-style bus arbiter.
// Bus widths, FSM state enum, response FIFO entry and beat-count helper.
package avl_bus_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int BURST_W = 8;
  localparam int MAX_M   = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    ST_IDLE,
    ST_WR_BURST
  } arb_state_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [BURST_W-1:0] beats;
  } resp_entry_t;

  // A zero burst_count still moves one beat.
  function automatic logic [BURST_W-1:0] beat_count(
    input logic               bb,
    input logic [BURST_W-1:0] bc
  );
    if (!bb || bc == '0) return BURST_W'(1);
    return bc;
  endfunction

endpackage

// File: rtl/avl_bus_arbiter_if.sv
// Avalon-style bus bundle: request channel plus pipelined read response.
// master drives address/byte_en/read/write/write_data/burst/resp_ready.
interface i_avl_bus;
  import avl_bus_pkg::*;

  logic [ADDR_W-1:0]  address;
  logic [BE_W-1:0]    byte_en;
  logic               read;
  logic               write;
  logic [DATA_W-1:0]  write_data;
  logic               begin_burst_transfer;
  logic [BURST_W-1:0] burst_count;
  logic               request_ready;
  logic [DATA_W-1:0]  read_data;
  logic               read_data_valid;
  logic               resp_ready;

  modport master (
    output address, byte_en, read, write,
    output write_data, begin_burst_transfer,
    output burst_count, resp_ready,
    input  request_ready, read_data,
    input  read_data_valid
  );

  modport slave (
    input  address, byte_en, read, write,
    input  write_data, begin_burst_transfer,
    input  burst_count, resp_ready,
    output request_ready, read_data,
    output read_data_valid
  );

endinterface

// File: rtl/avl_bus_arbiter_resp_fifo.sv
// Sync FIFO of outstanding read bursts {master id, beats}.
// Ports: clk, rst_n, push/wdata, pop/rdata, full, empty.
module avl_resp_fifo
  import avl_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  resp_entry_t wdata,
  input  logic        pop,
  output resp_entry_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  resp_entry_t   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avl_bus_arbiter.sv
// Round-robin arbiter of MASTER_NUM bus masters onto one slave.
// Ports: clk, rst_n, avl_in[] (masters), avl_out (slave), resp_err.
module avl_bus_arbiter
  import avl_bus_pkg::*;
#(
  parameter int MASTER_NUM      = 4,
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  i_avl_bus.slave  avl_in [MASTER_NUM],
  i_avl_bus.master avl_out,
  output logic     resp_err
);

  logic [ADDR_W-1:0]  m_addr  [MAX_M];
  logic [BE_W-1:0]    m_be    [MAX_M];
  logic [DATA_W-1:0]  m_wdata [MAX_M];
  logic [BURST_W-1:0] m_bc    [MAX_M];
  logic [MAX_M-1:0]   m_rd;
  logic [MAX_M-1:0]   m_wr;
  logic [MAX_M-1:0]   m_bb;
  logic [MAX_M-1:0]   m_rsp_rdy;

  arb_state_t         state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    lock_id;
  logic [BURST_W-1:0] remaining;
  logic [BURST_W-1:0] rsp_cnt;

  logic [MAX_M-1:0]   elig;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    cand;
  logic [BURST_W-1:0] beats;
  logic               wr_acc;
  logic               rd_acc;

  logic               fifo_full;
  logic               fifo_empty;
  resp_entry_t        head;
  resp_entry_t        push_ent;
  logic               rsp_rdy_out;
  logic               rsp_beat;
  logic               rsp_last;

  for (genvar g = 0; g < MAX_M; g++) begin : g_m
    if (g < MASTER_NUM) begin : g_on
      assign m_addr[g]    = avl_in[g].address;
      assign m_be[g]      = avl_in[g].byte_en;
      assign m_wdata[g]   = avl_in[g].write_data;
      assign m_bc[g]      = avl_in[g].burst_count;
      assign m_rd[g]      = avl_in[g].read;
      assign m_wr[g]      = avl_in[g].write;
      assign m_bb[g]      = avl_in[g].begin_burst_transfer;
      assign m_rsp_rdy[g] = avl_in[g].resp_ready;

      assign avl_in[g].request_ready =
        rst_n & gnt_valid &
        (gnt_id == ID_W'(g)) &
        avl_out.request_ready;
      assign avl_in[g].read_data = avl_out.read_data;
      assign avl_in[g].read_data_valid =
        rst_n & ~fifo_empty &
        (head.id == ID_W'(g)) &
        avl_out.read_data_valid;
    end else begin : g_off
      assign m_addr[g]    = '0;
      assign m_be[g]      = '0;
      assign m_wdata[g]   = '0;
      assign m_bc[g]      = '0;
      assign m_rd[g]      = 1'b0;
      assign m_wr[g]      = 1'b0;
      assign m_bb[g]      = 1'b0;
      assign m_rsp_rdy[g] = 1'b0;
    end
  end

  // Reads are not eligible while every response slot is taken.
  always_comb begin
    elig = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      elig[i] = m_wr[i] | (m_rd[i] & ~fifo_full);
    end
  end

  // Scan from farthest to nearest so the nearest candidate wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = last_grant;
    cand      = '0;
    if (state == ST_WR_BURST) begin
      gnt_valid = 1'b1;
      gnt_id    = lock_id;
    end else begin
      for (int k = MASTER_NUM; k >= 1; k--) begin
        cand = ID_W'((int'(last_grant) + k) % MASTER_NUM);
        if (elig[cand]) begin
          gnt_valid = 1'b1;
          gnt_id    = cand;
        end
      end
    end
  end

  assign beats = beat_count(m_bb[gnt_id], m_bc[gnt_id]);

  assign avl_out.address              = m_addr[gnt_id];
  assign avl_out.byte_en              = m_be[gnt_id];
  assign avl_out.write_data           = m_wdata[gnt_id];
  assign avl_out.begin_burst_transfer = m_bb[gnt_id];
  assign avl_out.burst_count          = m_bc[gnt_id];

  // Write wins if a master raises both; burst beats never carry reads.
  assign avl_out.write = rst_n & gnt_valid & m_wr[gnt_id];
  assign avl_out.read  =
    rst_n & gnt_valid & (state == ST_IDLE) &
    m_rd[gnt_id] & ~m_wr[gnt_id] & ~fifo_full;

  assign wr_acc = avl_out.write & avl_out.request_ready;
  assign rd_acc = avl_out.read & avl_out.request_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(MASTER_NUM - 1);
      lock_id    <= '0;
      remaining  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (wr_acc || rd_acc) begin
            last_grant <= gnt_id;
            if (wr_acc && beats > BURST_W'(1)) begin
              state     <= ST_WR_BURST;
              lock_id   <= gnt_id;
              remaining <= beats - BURST_W'(1);
            end
          end
        end
        ST_WR_BURST: begin
          if (wr_acc) begin
            remaining <= remaining - BURST_W'(1);
            if (remaining == BURST_W'(1)) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign push_ent = '{id: gnt_id, beats: beats};

  avl_resp_fifo #(
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_acc),
    .wdata (push_ent),
    .pop   (rsp_last),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_rdy_out =
    rst_n & ~fifo_empty & m_rsp_rdy[head.id];
  assign avl_out.resp_ready = rsp_rdy_out;

  assign rsp_beat = avl_out.read_data_valid & rsp_rdy_out;
  assign rsp_last =
    rsp_beat & (rsp_cnt == head.beats - BURST_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_cnt  <= '0;
      resp_err <= 1'b0;
    end else begin
      if (rsp_beat) begin
        rsp_cnt <= rsp_last ? '0 : rsp_cnt + BURST_W'(1);
      end
      // Response with nothing outstanding is dropped.
      if (avl_out.read_data_valid && fifo_empty) begin
        resp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// Directed bench for avl_bus_arbiter with 4 masters, FIFO depth 4.
// Drives masters through arrays; checks with immediate assertions.
module tb_avl_bus_arbiter;
  import avl_bus_pkg::*;

  logic clk;
  logic rst_n;
  logic resp_err;

  logic [3:0] rd, wr, bb, rsp_rdy;
  logic [7:0] bc [4];
  logic [3:0] rrv, rdv;
  logic [31:0] rdat [4];

  int npass;
  int ntot;

  i_avl_bus m_bus [4] ();
  i_avl_bus s_bus ();

  for (genvar g = 0; g < 4; g++) begin : g_m
    assign m_bus[g].address              = 32'((g + 1) << 12);
    assign m_bus[g].byte_en              = 4'hF;
    assign m_bus[g].write_data           = 32'hD000 + 32'(g);
    assign m_bus[g].read                 = rd[g];
    assign m_bus[g].write                = wr[g];
    assign m_bus[g].begin_burst_transfer = bb[g];
    assign m_bus[g].burst_count          = bc[g];
    assign m_bus[g].resp_ready           = rsp_rdy[g];
    assign rrv[g]  = m_bus[g].request_ready;
    assign rdv[g]  = m_bus[g].read_data_valid;
    assign rdat[g] = m_bus[g].read_data;
  end

  avl_bus_arbiter #(
    .MASTER_NUM      (4),
    .RESP_FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .avl_in   (m_bus),
    .avl_out  (s_bus),
    .resp_err (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ma(input int id);
    return 32'((id + 1) << 12);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  // Drive point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    rst_n = 1'b0;
    rd = '0; wr = 4'b0001; bb = '0; rsp_rdy = 4'hF;
    for (int i = 0; i < 4; i++) bc[i] = 8'd1;
    s_bus.request_ready   = 1'b1;
    s_bus.read_data       = '0;
    s_bus.read_data_valid = 1'b0;

    tick(); tick();
    settle();
    chk("rst_read", 32'(s_bus.read), 0);
    chk("rst_write", 32'(s_bus.write), 0);
    chk("rst_resp_ready", 32'(s_bus.resp_ready), 0);
    chk("rst_rrv", 32'(rrv), 0);
    chk("rst_rdv", 32'(rdv), 0);

    tick();
    rst_n = 1'b1; wr = '0;
    settle();
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst_empty", 32'(dut.u_fifo.empty), 1);
    chk("rst_err", 32'(resp_err), 0);

    // Alternating single writes from masters 0 and 2.
    for (int i = 0; i < 4; i++) begin
      tick();
      wr = 4'b0101;
      settle();
      chk("alt_addr", s_bus.address, ma((i % 2 == 0) ? 0 : 2));
      chk("alt_write", 32'(s_bus.write), 1);
      chk("alt_rrv", 32'(rrv), (i % 2 == 0) ? 1 : 4);
    end

    // 4-beat write burst from master 1, master 3 waiting.
    tick();
    wr = 4'b0010; bb[1] = 1'b1; bc[1] = 8'd4;
    settle();
    chk("b1_addr", s_bus.address, ma(1));
    chk("b1_rrv", 32'(rrv), 32'b0010);
    tick();
    wr = 4'b1010;
    settle();
    chk("b2_addr", s_bus.address, ma(1));
    chk("b2_state", 32'(dut.state), 32'(ST_WR_BURST));
    for (int i = 0; i < 2; i++) begin
      tick();
      s_bus.request_ready = 1'b0;
      settle();
      chk("bstall_addr", s_bus.address, ma(1));
      chk("bstall_rrv", 32'(rrv), 0);
    end
    tick();
    s_bus.request_ready = 1'b1;
    settle();
    chk("b5_addr", s_bus.address, ma(1));
    tick();
    settle();
    chk("b6_addr", s_bus.address, ma(1));
    chk("b6_rrv", 32'(rrv), 32'b0010);
    tick();
    wr = 4'b1000; bb = '0; bc[1] = 8'd1;
    settle();
    chk("b7_state", 32'(dut.state), 32'(ST_IDLE));
    chk("b7_addr", s_bus.address, ma(3));
    chk("b7_rrv", 32'(rrv), 32'b1000);

    // Reads of 2 and 3 beats, 5 response beats routed in order.
    tick();
    wr = '0; rd = 4'b0001; bb[0] = 1'b1; bc[0] = 8'd2;
    settle();
    chk("c1_read", 32'(s_bus.read), 1);
    chk("c1_addr", s_bus.address, ma(0));
    chk("c1_bc", 32'(s_bus.burst_count), 2);
    tick();
    rd = 4'b0010; bb = 4'b0010; bc[0] = 8'd1; bc[1] = 8'd3;
    settle();
    chk("c2_read", 32'(s_bus.read), 1);
    chk("c2_addr", s_bus.address, ma(1));
    for (int i = 1; i <= 5; i++) begin
      tick();
      rd = '0; bb = '0; bc[1] = 8'd1;
      s_bus.read_data_valid = 1'b1;
      s_bus.read_data = 32'hA0 + 32'(i);
      settle();
      chk("c_rdv", 32'(rdv), (i <= 2) ? 1 : 2);
      chk("c_resp_ready", 32'(s_bus.resp_ready), 1);
      chk("c_bcast", rdat[3], 32'hA0 + 32'(i));
    end
    tick();
    s_bus.read_data_valid = 1'b0;
    settle();
    chk("c_empty", 32'(dut.u_fifo.empty), 1);
    chk("c_rdv_idle", 32'(rdv), 0);

    // Fill the response FIFO: grants 2,3,0,1.
    for (int i = 0; i < 4; i++) begin
      tick();
      rd = 4'b1111;
      settle();
      chk("d_read", 32'(s_bus.read), 1);
      chk("d_addr", s_bus.address, ma((i + 2) % 4));
    end
    tick();
    rd = 4'b0001; wr = 4'b0100;
    settle();
    chk("d5_full", 32'(dut.u_fifo.full), 1);
    chk("d5_read", 32'(s_bus.read), 0);
    chk("d5_write", 32'(s_bus.write), 1);
    chk("d5_addr", s_bus.address, ma(2));
    tick();
    wr = '0;
    s_bus.read_data_valid = 1'b1;
    settle();
    chk("d6_read", 32'(s_bus.read), 0);
    chk("d6_rrv", 32'(rrv), 0);
    chk("d6_rdv", 32'(rdv), 32'b0100);
    tick();
    s_bus.read_data_valid = 1'b0;
    settle();
    chk("d7_read", 32'(s_bus.read), 1);
    chk("d7_addr", s_bus.address, ma(0));
    chk("d7_rrv", 32'(rrv), 32'b0001);

    // Head master 3 stalls its response for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      rd = '0;
      s_bus.read_data_valid = 1'b1;
      rsp_rdy = 4'b0111;
      settle();
      chk("e_resp_ready", 32'(s_bus.resp_ready), 0);
      chk("e_rdv", 32'(rdv), 32'b1000);
      chk("e_full", 32'(dut.u_fifo.full), 1);
    end
    tick();
    rsp_rdy = 4'hF;
    settle();
    chk("e4_resp_ready", 32'(s_bus.resp_ready), 1);
    tick();
    settle();
    chk("e5_full", 32'(dut.u_fifo.full), 0);
    chk("e5_rdv", 32'(rdv), 32'b0001);
    tick();
    s_bus.read_data_valid = 1'b0;
    settle();
    chk("e6_empty", 32'(dut.u_fifo.empty), 0);

    // Reset mid write burst with 2 reads outstanding.
    tick();
    wr = 4'b0100; bb = 4'b0100; bc[2] = 8'd4;
    settle();
    chk("f1_addr", s_bus.address, ma(2));
    chk("f1_write", 32'(s_bus.write), 1);
    tick();
    rst_n = 1'b0;
    s_bus.read_data_valid = 1'b1;
    settle();
    chk("f2_state", 32'(dut.state), 32'(ST_WR_BURST));
    chk("f2_write", 32'(s_bus.write), 0);
    chk("f2_rrv", 32'(rrv), 0);
    chk("f2_resp_ready", 32'(s_bus.resp_ready), 0);
    chk("f2_rdv", 32'(rdv), 0);
    tick();
    rst_n = 1'b1;
    wr = '0; bb = '0; bc[2] = 8'd1;
    s_bus.read_data_valid = 1'b0;
    settle();
    chk("f3_state", 32'(dut.state), 32'(ST_IDLE));
    chk("f3_empty", 32'(dut.u_fifo.empty), 1);
    chk("f3_write", 32'(s_bus.write), 0);
    chk("f3_resp_ready", 32'(s_bus.resp_ready), 0);

    // Fresh write with burst_count 0 counts as one beat.
    tick();
    wr = 4'b0010; bb = 4'b0010; bc[1] = 8'd0;
    settle();
    chk("f4_addr", s_bus.address, ma(1));
    chk("f4_rrv", 32'(rrv), 32'b0010);
    tick();
    wr = '0; bb = '0; bc[1] = 8'd1;
    s_bus.read_data_valid = 1'b1;
    settle();
    chk("f5_state", 32'(dut.state), 32'(ST_IDLE));
    chk("f5_rdv", 32'(rdv), 0);
    chk("f5_err", 32'(resp_err), 0);
    tick();
    s_bus.read_data_valid = 1'b0;
    settle();
    chk("f6_err", 32'(resp_err), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
